// File: rtl/abnormality_alarm_controller.sv
// ---------------------------------------------------------------------------
// abnormality_alarm_controller
//
// Purpose:
//   Sits downstream of the temperature, pressure and blood-sugar analyzers.
//   Each combinational abnormality flag is debounced into a "qualified" flag.
//   Any qualified flag raises a latched alarm that holds until a caregiver
//   acknowledges it. The controller remembers which vital signs caused the
//   alarm and, while the alarm is unacknowledged, re-pulses the alert
//   periodically so the display/alert logic keeps nagging.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive high samples needed to qualify a flag (>=1)
//   REALERT_CYCLES   spacing in cycles of repeated alarm pulses (>=2)
//
// Ports:
//   i_clk                     system clock, rising edge
//   i_resetN                  asynchronous active-low reset
//   i_temperatureAbnormality  raw flag from the temperature analyzer
//   i_pressureAbnormality     raw flag from the pressure analyzer
//   i_bloodSugarAbnormality   raw flag from the blood-sugar analyzer
//   i_ack                     caregiver acknowledge (level)
//   o_alarm                   high while an unacknowledged alarm is active
//   o_alarmPulse              one-cycle strobe on alarm entry and each re-alert
//   o_alarmCause[2:0]         sticky causes: bit0 temp, bit1 pressure, bit2 sugar
//   o_qualified[2:0]          current debounced flags, same bit order
//
// All outputs come straight from flops; there is no combinational path from
// any input to any output.
// ---------------------------------------------------------------------------
module abnormality_alarm_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REALERT_CYCLES  = 1000
) (
    input  logic       i_clk,
    input  logic       i_resetN,
    input  logic       i_temperatureAbnormality,
    input  logic       i_pressureAbnormality,
    input  logic       i_bloodSugarAbnormality,
    input  logic       i_ack,
    output logic       o_alarm,
    output logic       o_alarmPulse,
    output logic [2:0] o_alarmCause,
    output logic [2:0] o_qualified
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_W = $clog2(REALERT_CYCLES);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REALERT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALERT = 2'd1,
        ACKED = 2'd2
    } state_t;

    logic [2:0]       w_flags;
    logic [CNT_W-1:0] r_cnt [3];
    logic [2:0]       r_qualified;

    state_t           r_state;
    state_t           w_nextState;
    logic [2:0]       r_cause;
    logic [2:0]       w_nextCause;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_nextTimer;
    logic             w_nextPulse;
    logic             r_pulse;
    logic             r_alarm;
    logic [2:0]       w_newCause;

    assign w_flags = {i_bloodSugarAbnormality, i_pressureAbnormality,
                      i_temperatureAbnormality};

    // Debounce: each channel counts consecutive high samples and saturates.
    // The qualified bit is set on the same edge the count reaches its limit
    // (i.e. when the pre-edge count is one short), and stays set while the
    // count sits saturated. A single low sample clears both at once.
    always_ff @(posedge i_clk or negedge i_resetN) begin
        if (!i_resetN) begin
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
            r_qualified <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_flags[i]) begin
                    if (r_cnt[i] != CNT_MAX) begin
                        r_cnt[i] <= r_cnt[i] + CNT_ONE;
                    end
                    r_qualified[i] <= (r_cnt[i] == CNT_LAST) ||
                                      (r_cnt[i] == CNT_MAX);
                end else begin
                    r_cnt[i]       <= '0;
                    r_qualified[i] <= 1'b0;
                end
            end
        end
    end

    // Qualified bits that are not yet part of the remembered cause; only
    // these can pull an acknowledged alarm back into ALERT.
    assign w_newCause = r_qualified & ~r_cause;

    // Next-state logic. The FSM reacts to the registered qualified flags, so
    // the alarm rises one edge after a flag qualifies. In ALERT an ack always
    // wins over a simultaneous new cause: the cause is absorbed into the
    // sticky set, which is why it can no longer trigger re-entry later.
    always_comb begin
        w_nextState = r_state;
        w_nextCause = r_cause;
        w_nextTimer = r_timer;
        w_nextPulse = 1'b0;

        case (r_state)
            IDLE: begin
                w_nextCause = '0;
                if (r_qualified != 3'b000) begin
                    w_nextState = ALERT;
                    w_nextCause = r_qualified;
                    w_nextTimer = '0;
                    w_nextPulse = 1'b1;
                end
            end

            ALERT: begin
                w_nextCause = r_cause | r_qualified;
                if (i_ack) begin
                    w_nextState = ACKED;
                    w_nextTimer = '0;
                end else if (r_timer == TMR_LAST) begin
                    // Wrapping here puts each re-alert exactly REALERT_CYCLES
                    // edges after the previous pulse.
                    w_nextTimer = '0;
                    w_nextPulse = 1'b1;
                end else begin
                    w_nextTimer = r_timer + TMR_ONE;
                end
            end

            ACKED: begin
                if (w_newCause != 3'b000) begin
                    w_nextState = ALERT;
                    w_nextCause = r_cause | r_qualified;
                    w_nextTimer = '0;
                    w_nextPulse = 1'b1;
                end else if (r_qualified == 3'b000) begin
                    w_nextState = IDLE;
                    w_nextCause = '0;
                end
            end

            default: begin
                w_nextState = IDLE;
                w_nextCause = '0;
                w_nextTimer = '0;
            end
        endcase
    end

    // State and output registers. The alarm flop is loaded from the next
    // state so it is a true register aligned with the state change.
    always_ff @(posedge i_clk or negedge i_resetN) begin
        if (!i_resetN) begin
            r_state <= IDLE;
            r_cause <= '0;
            r_timer <= '0;
            r_pulse <= 1'b0;
            r_alarm <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_cause <= w_nextCause;
            r_timer <= w_nextTimer;
            r_pulse <= w_nextPulse;
            r_alarm <= (w_nextState == ALERT);
        end
    end

    assign o_alarm      = r_alarm;
    assign o_alarmPulse = r_pulse;
    assign o_alarmCause = r_cause;
    assign o_qualified  = r_qualified;

endmodule
